// File: rtl/pong_vga_pkg.sv
// Default 640x480@60 raster constants and shared helpers for the pong VGA timing block.
package pong_vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned CW_DEF       = 10;

    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    typedef logic [CW_DEF-1:0] coord_t;

    // Map a logical "sync asserted" flag onto the physical pin level.
    function automatic logic sync_level(input logic active, input logic active_high);
        return active_high ? active : ~active;
    endfunction

endpackage

// File: rtl/pong_vga_axis_counter.sv
// One raster axis counter: counts 0..TOTAL-1 and wraps. Advances when step and wrap_in are
// both high, so chaining the horizontal wrap into wrap_in of the vertical counter gives a
// carry chain; wrap flags the cycle on which this counter rolls over to 0.
module pong_vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          wrap_in,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          adv;
    logic          at_last;

    // Next count: hold, increment, or roll over at the terminal value.
    always_comb begin
        adv     = step && wrap_in;
        at_last = (count_q == LAST);
        count_d = count_q;
        if (adv) begin
            count_d = at_last ? '0 : count_q + ONE;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = adv && at_last;

endmodule

// File: rtl/pong_vga_timing.sv
// Raster timing generator for pong: registered syncs, display enable, pixel coordinates and
// game-update strobes. All outputs come from one register stage decoded from the (hc, vc)
// counters, so they stay mutually aligned and lag the counters by one cycle.
// Optional build macro PONG_VGA_FRAME_COUNT_EN adds an 8-bit frame_count output.
module pong_vga_timing
    import pong_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE         = H_ACTIVE_DEF,
    parameter int unsigned H_FP             = H_FP_DEF,
    parameter int unsigned H_SYNC           = H_SYNC_DEF,
    parameter int unsigned H_BP             = H_BP_DEF,
    parameter int unsigned V_ACTIVE         = V_ACTIVE_DEF,
    parameter int unsigned V_FP             = V_FP_DEF,
    parameter int unsigned V_SYNC           = V_SYNC_DEF,
    parameter int unsigned V_BP             = V_BP_DEF,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0,
    parameter int unsigned CW               = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_tick
`ifdef PONG_VGA_FRAME_COUNT_EN
    ,
    output logic [7:0]    frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START_C = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START_C = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_HI    = (SYNC_ACTIVE_HIGH != 0);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          h_wrap;
    logic          v_wrap;
    logic          unused_v_wrap;

    pong_vga_axis_counter #(
        .TOTAL(H_TOTAL),
        .CW   (CW)
    ) u_h_counter (
        .clk    (clk),
        .rst    (rst),
        .step   (ena),
        .wrap_in(1'b1),
        .count  (hc),
        .wrap   (h_wrap)
    );

    pong_vga_axis_counter #(
        .TOTAL(V_TOTAL),
        .CW   (CW)
    ) u_v_counter (
        .clk    (clk),
        .rst    (rst),
        .step   (ena),
        .wrap_in(h_wrap),
        .count  (vc),
        .wrap   (v_wrap)
    );

    // Frame boundaries are decoded directly from (hc, vc); the vertical wrap is not needed.
    assign unused_v_wrap = v_wrap;

    logic          hs_act;
    logic          vs_act;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          vblank_tick_q, vblank_tick_d;

    // Decode the current counter position; hold everything while ena is low.
    always_comb begin
        hs_act        = (hc >= HS_START_C) && (hc < HS_END_C);
        vs_act        = (vc >= VS_START_C) && (vc < VS_END_C);
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        vblank_tick_d = vblank_tick_q;
        if (ena) begin
            hsync_d       = sync_level(hs_act, SYNC_HI);
            vsync_d       = sync_level(vs_act, SYNC_HI);
            de_d          = (hc < H_ACT_C) && (vc < V_ACT_C);
            pixel_x_d     = hc;
            pixel_y_d     = vc;
            line_start_d  = (hc == '0);
            frame_start_d = (hc == '0) && (vc == '0);
            vblank_tick_d = (hc == '0) && (vc == V_ACT_C);
        end
    end

    // Output register stage; reset drives syncs to their inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~SYNC_HI;
            vsync_q       <= ~SYNC_HI;
            de_q          <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_tick_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_tick_q <= vblank_tick_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vblank_tick = vblank_tick_q;

`ifdef PONG_VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_q, frame_count_d;

    // Bump the frame counter together with the registered frame_start pulse.
    always_comb begin
        frame_count_d = frame_count_q;
        if (ena && (hc == '0) && (vc == '0)) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_pong_vga_timing.sv
// Bench for pong_vga_timing: a default 640x480 instance plus a tiny-raster instance
// (H 4/1/2/1, V 3/1/1/1, active-high syncs) share clk/rst/ena. A per-cycle scoreboard
// compares both against a raster model; a phase table checks hand-counted aggregates.
module tb_pong_vga_timing;
    import pong_vga_pkg::*;

    typedef struct packed {
        logic   hs;
        logic   vs;
        logic   de;
        coord_t px;
        coord_t py;
        logic   ls;
        logic   fs;
        logic   vt;
    } obs_t;

    typedef struct {
        logic ena;
        int   cycles;
        int   exp_de;
        int   exp_hs_low;
        int   exp_ls;
        int   exp_fs;
        int   exp_px_end;
        int   exp_py_end;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;

    always #5 clk = ~clk;

    logic   d_hs, d_vs, d_de, d_ls, d_fs, d_vt;
    coord_t d_px, d_py;
    logic   s_hs, s_vs, s_de, s_ls, s_fs, s_vt;
    coord_t s_px, s_py;
`ifdef PONG_VGA_FRAME_COUNT_EN
    logic [7:0] d_fc, s_fc;
`endif

    pong_vga_timing u_dut_def (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .de         (d_de),
        .pixel_x    (d_px),
        .pixel_y    (d_py),
        .line_start (d_ls),
        .frame_start(d_fs),
        .vblank_tick(d_vt)
`ifdef PONG_VGA_FRAME_COUNT_EN
        ,
        .frame_count(d_fc)
`endif
    );

    pong_vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_HIGH(1), .CW(10)
    ) u_dut_small (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .de         (s_de),
        .pixel_x    (s_px),
        .pixel_y    (s_py),
        .line_start (s_ls),
        .frame_start(s_fs),
        .vblank_tick(s_vt)
`ifdef PONG_VGA_FRAME_COUNT_EN
        ,
        .frame_count(s_fc)
`endif
    );

    obs_t obs_d, obs_s;
    assign obs_d = {d_hs, d_vs, d_de, d_px, d_py, d_ls, d_fs, d_vt};
    assign obs_s = {s_hs, s_vs, s_de, s_px, s_py, s_ls, s_fs, s_vt};

    int n_checks = 0;
    int n_fail   = 0;

    int   mh_d = 0, mv_d = 0, mh_s = 0, mv_s = 0;
    obs_t hold_d, hold_s;
    obs_t q_d[$];
    obs_t q_s[$];

    function automatic obs_t decode(input int h, input int v, input int ha, input int hf,
                                    input int hsw, input int va, input int vf, input int vsw,
                                    input bit hi);
        obs_t o;
        bit   h_act;
        bit   v_act;
        h_act = (h >= ha + hf) && (h < ha + hf + hsw);
        v_act = (v >= va + vf) && (v < va + vf + vsw);
        o.hs  = hi ? h_act : !h_act;
        o.vs  = hi ? v_act : !v_act;
        o.de  = (h < ha) && (v < va);
        o.px  = coord_t'(h);
        o.py  = coord_t'(v);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.vt  = (h == 0) && (v == va);
        return o;
    endfunction

    function automatic obs_t reset_obs(input bit hi);
        obs_t o;
        o    = '0;
        o.hs = !hi;
        o.vs = !hi;
        return o;
    endfunction

    task automatic advance(inout int h, inout int v, input int ht, input int vtot);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vtot - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    task automatic check1(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(input string name, input obs_t exp, input obs_t act);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got hs%b vs%b de%b x%0d y%0d ls%b fs%b vt%b, expected hs%b vs%b de%b x%0d y%0d ls%b fs%b vt%b (t=%0t)",
                     name, act.hs, act.vs, act.de, act.px, act.py, act.ls, act.fs, act.vt,
                     exp.hs, exp.vs, exp.de, exp.px, exp.py, exp.ls, exp.fs, exp.vt, $time);
        end
    endtask

    // Drive one cycle, push model expectations, then compare both instances after the edge.
    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        ena = e;
        if (r) begin
            mh_d   = 0; mv_d = 0; mh_s = 0; mv_s = 0;
            hold_d = reset_obs(1'b0);
            hold_s = reset_obs(1'b1);
        end else if (e) begin
            hold_d = decode(mh_d, mv_d, 640, 16, 96, 480, 10, 2, 1'b0);
            hold_s = decode(mh_s, mv_s, 4, 1, 2, 3, 1, 1, 1'b1);
            advance(mh_d, mv_d, 800, 525);
            advance(mh_s, mv_s, 8, 6);
        end
        q_d.push_back(hold_d);
        q_s.push_back(hold_s);
        @(posedge clk);
        #1;
        check_obs("trace_def", q_d.pop_front(), obs_d);
        check_obs("trace_small", q_s.pop_front(), obs_s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   c_de, c_hs, c_ls, c_fs;
        int   period, vs_cnt, vt_cnt;
        bit   found;
        bit   e;

        // Phases following the first enabled cycle; counts are of the default instance.
        vecs[0] = '{1'b1, 799, 639, 96, 0, 0, 799, 0};
        vecs[1] = '{1'b1, 300, 300, 0, 1, 0, 299, 1};
        vecs[2] = '{1'b0, 37, 37, 0, 0, 0, 299, 1};
        vecs[3] = '{1'b1, 500, 340, 96, 0, 0, 799, 1};

        repeat (3) step(1'b1, 1'b1);
        check1("reset_hsync", int'(d_hs), 1);
        check1("reset_vsync", int'(d_vs), 1);
        check1("reset_de", int'(d_de), 0);
        check1("reset_px", int'(d_px), 0);
        check1("reset_strobes", int'({d_ls, d_fs, d_vt}), 0);
        check1("reset_small_syncs", int'({s_hs, s_vs}), 0);

        step(1'b0, 1'b1);
        check1("first_px", int'(d_px), 0);
        check1("first_py", int'(d_py), 0);
        check1("first_de", int'(d_de), 1);
        check1("first_line_start", int'(d_ls), 1);
        check1("first_frame_start", int'(d_fs), 1);

        for (int i = 0; i < 4; i++) begin
            c_de = 0; c_hs = 0; c_ls = 0; c_fs = 0;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(1'b0, vecs[i].ena);
                c_de += int'(d_de);
                c_hs += int'(!d_hs);
                c_ls += int'(d_ls);
                c_fs += int'(d_fs);
            end
            check1($sformatf("vec%0d_de_count", i), c_de, vecs[i].exp_de);
            check1($sformatf("vec%0d_hsync_low_count", i), c_hs, vecs[i].exp_hs_low);
            check1($sformatf("vec%0d_line_start_count", i), c_ls, vecs[i].exp_ls);
            check1($sformatf("vec%0d_frame_start_count", i), c_fs, vecs[i].exp_fs);
            check1($sformatf("vec%0d_px_end", i), int'(d_px), vecs[i].exp_px_end);
            check1($sformatf("vec%0d_py_end", i), int'(d_py), vecs[i].exp_py_end);
        end

        // Small raster: one frame with a 37-cycle freeze must last 48 + 37 cycles.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b0, 1'b1);
            if (s_fs) found = 1'b1;
        end
        check1("small_fs_wait", int'(found), 1);
        period = 0; vs_cnt = 0; vt_cnt = 0; found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            e = !(i >= 10 && i < 47);
            step(1'b0, e);
            period++;
            if (e && s_fs) begin
                found = 1'b1;
            end else begin
                vs_cnt += int'(s_vs);
                vt_cnt += int'(s_vt);
            end
        end
        check1("small_frame_found", int'(found), 1);
        check1("small_frame_period", period, 85);
        check1("small_vsync_cycles", vs_cnt, 8);
        check1("small_vblank_ticks", vt_cnt, 1);

        // Reset in the middle of the small instance's sync pulses.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b0, 1'b1);
            if (s_py == 4 && s_px == 5) found = 1'b1;
        end
        check1("small_sync_wait", int'(found), 1);
        check1("small_sync_active", int'({s_hs, s_vs}), 3);
        step(1'b1, 1'b1);
        check1("midreset_small_syncs", int'({s_hs, s_vs}), 0);
        check1("midreset_small_de", int'(s_de), 0);
        check1("midreset_small_xy", int'(s_px) + int'(s_py), 0);
        check1("midreset_def_syncs", int'({d_hs, d_vs}), 3);
        step(1'b0, 1'b1);
        check1("post_reset_small_fs", int'(s_fs), 1);
        check1("post_reset_def_fs", int'(d_fs), 1);

`ifdef PONG_VGA_FRAME_COUNT_EN
        begin
            int nfs;
            step(1'b1, 1'b1);
            check1("fc_reset_small", int'(s_fc), 0);
            check1("fc_reset_def", int'(d_fc), 0);
            nfs = 0;
            for (int c = 0; c < 257 * 48; c++) begin
                step(1'b0, 1'b1);
                if (s_fs) begin
                    nfs++;
                    check1("frame_count", int'(s_fc), nfs % 256);
                end
            end
            check1("frame_pulses", nfs, 257);
            check1("fc_def_after", int'(d_fc), 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_vga_timing.md
Name: pong_vga_timing

Overview:
- Raster timing generator for the pong design; sits directly upstream of the pong renderer/top-level output mux.
- Produces registered hsync, vsync, display-enable and pixel coordinates, plus strobes that tell the game logic when to update.
- Default timing is 640x480 @ 60 Hz from a 25.175 MHz (nominally 25 MHz) pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, 0 = sync pulses drive low, 1 = sync pulses drive high
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  count enable; low freezes all state and outputs
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
- de  out  1  high while (pixel_x, pixel_y) is inside the active area
- pixel_x  out  CW  column of the current output pixel
- pixel_y  out  CW  row of the current output pixel
- line_start  out  1  one-cycle pulse when pixel_x==0
- frame_start  out  1  one-cycle pulse when pixel_x==0 and pixel_y==0
- vblank_tick  out  1  one-cycle pulse when pixel_x==0 and pixel_y==V_ACTIVE; game-state update strobe

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = the vertical equivalent (525).
- Two internal counters:
  - hc runs 0..H_TOTAL-1 and wraps to 0.
  - vc advances only on the hc wrap, runs 0..V_TOTAL-1 and wraps to 0 on the same cycle that hc wraps at vc==V_TOTAL-1.
- Output stage: one register stage. Every output is decoded from (hc, vc) and registered, so all outputs are mutually aligned; pixel_x/pixel_y equal the hc/vc of the previous cycle.
- Decode:
  - de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - hsync active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, across the whole line.
  - The inactive sync level is the complement of the active level.
- Reset, while rst is high:
  - hc=0, vc=0.
  - Outputs: hsync/vsync inactive, de=0, pixel_x=0, pixel_y=0, all strobes 0.
  - On the first enabled cycle after rst deasserts, counters advance to hc=1. Outputs then show pixel_x=0, pixel_y=0, de=1, line_start=1, frame_start=1.
- ena low: counters and output registers hold. Strobes stay at their held value; the consumer qualifies strobes with ena.
- rst has priority over ena. Reset mid-frame restarts cleanly at (0,0), with no partial sync pulse beyond the reset cycle.
- Counter arithmetic is unsigned CW-bit. Compares are against elaborated constants; no divide or multiply.

Optional Feature:
- Macro: PONG_VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count [7:0], which resets to 0.
  - It increments by 1, modulo 256, in the same cycle that frame_start is asserted.
  - It is used by the pong logic for ball-speed ramp and blink effects.
- Undefined: the port and the register are absent; all other behaviour is identical.

Decomposition:
- Package pong_vga_pkg:
  - Default 640x480 timing constants.
  - Derived H_TOTAL/V_TOTAL, sync start/end localparams.
  - Coordinate typedef coord_t (CW-bit unsigned).
- Sub-module pong_vga_axis_counter (parameters TOTAL, CW):
  - Inputs: step, wrap-in.
  - Outputs: count, wrap.
  - Instantiated once for horizontal and once for vertical; vertical step = horizontal wrap.

Test Plan:
- Reset then run 800 clocks, ena=1 -> pixel_x sequence 0..799 with no gap; line_start only at pixel_x==0; pixel_y goes 0->1 when pixel_x wraps.
- Sample one line -> de high for exactly 640 clocks; hsync low for exactly 96 clocks starting at pixel_x==656; SYNC_ACTIVE_HIGH=0.
- Run a full frame of 420000 clocks -> vsync low for exactly 1600 clocks at pixel_y 490..491; frame_start once per 420000 clocks; vblank_tick once, at (0,480).
- Toggle ena low for 37 clocks mid-line at pixel_x==300 -> all outputs frozen; resumes at pixel_x==301; frame period is extended by exactly 37 clocks.
- Assert rst for 1 clock at pixel_x==700, pixel_y==491 -> next cycle hsync/vsync inactive, de=0, coordinates 0; cycle after shows frame_start=1.
- Small-parameter build (H 4/1/2/1, V 3/1/1/1) with PONG_VGA_FRAME_COUNT_EN -> H_TOTAL=8, V_TOTAL=6; frame_count reads 0,1,...,255,0 across 257 frames of 48 clocks each.
